// File: rtl/softmax_argmax.sv
// Purpose : argmax over an N_CLASS float32 probability vector, one element compared per clock.
// Latency : result pulse in the cycle after edge k+N_CLASS-1 for a vector accepted at edge k.
// Backpressure: in_ready low while scanning; a vector offered then is dropped and overrun latches.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   valid_in, percent    one-cycle strobe with N_CLASS packed words (class i at [i*DW +: DW])
//   in_ready             high in IDLE, when a new vector is accepted
//   valid_out            one-cycle pulse qualifying class_idx / max_prob
//   class_idx, max_prob  winning index and bit-exact copy of its word (held until next result)
//   overrun              sticky flag, set by valid_in while scanning, cleared only by reset
//   thresh, low_conf     present only with CONF_THRESH_EN: low_conf=1 when max_prob < thresh
//
// Optional feature macro: CONF_THRESH_EN
module softmax_argmax #(
  parameter int N_CLASS = 10,
  parameter int DW      = 32,
  parameter int IW      = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  valid_in,
  input  logic [N_CLASS*DW-1:0] percent,
`ifdef CONF_THRESH_EN
  input  logic [DW-1:0]         thresh,
  output logic                  low_conf,
`endif
  output logic                  in_ready,
  output logic                  valid_out,
  output logic [IW-1:0]         class_idx,
  output logic [DW-1:0]         max_prob,
  output logic                  overrun
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  // Strict "a > b" under the float32 total order used for ranking.
  // Non-NaN words map to an unsigned key whose order matches numeric order:
  // positives get the top bit set, negatives are bit-inverted so larger
  // magnitudes sort lower. -0 is folded onto +0 first so the two tie.
  // A NaN on the left never wins; a NaN on the right always loses.
  function automatic logic f_gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic        a_nan;
    logic        b_nan;
    logic [DW-1:0] ka;
    logic [DW-1:0] kb;
    a_nan = (&a[30:23]) && (|a[22:0]);
    b_nan = (&b[30:23]) && (|b[22:0]);
    ka = (a[30:0] == 31'd0) ? {1'b1, 31'd0} : (a[31] ? ~a : {1'b1, a[30:0]});
    kb = (b[30:0] == 31'd0) ? {1'b1, 31'd0} : (b[31] ? ~b : {1'b1, b[30:0]});
    return !a_nan && (b_nan || (ka > kb));
  endfunction

  state_t        state_q,     state_d;
  logic [DW-1:0] bank_q [N_CLASS];
  logic [DW-1:0] bank_d [N_CLASS];
  logic [DW-1:0] best_q,      best_d;
  logic [IW-1:0] best_idx_q,  best_idx_d;
  logic [IW-1:0] cnt_q,       cnt_d;
  logic          in_ready_q,  in_ready_d;
  logic          valid_out_q, valid_out_d;
  logic [IW-1:0] class_idx_q, class_idx_d;
  logic [DW-1:0] max_prob_q,  max_prob_d;
  logic          overrun_q,   overrun_d;
`ifdef CONF_THRESH_EN
  logic [DW-1:0] thresh_q,    thresh_d;
  logic          low_conf_q,  low_conf_d;
`endif

  // Single comparator: current bank element against the running best.
  logic [DW-1:0] cand;
  logic          take;
  logic [DW-1:0] best_nxt;
  logic [IW-1:0] idx_nxt;

  always_comb begin
    cand     = bank_q[cnt_q];
    take     = f_gt(cand, best_q);
    best_nxt = take ? cand  : best_q;
    idx_nxt  = take ? cnt_q : best_idx_q;
  end

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    cnt_d       = cnt_q;
    valid_out_d = 1'b0;
    class_idx_d = class_idx_q;
    max_prob_d  = max_prob_q;
    overrun_d   = overrun_q;
`ifdef CONF_THRESH_EN
    thresh_d    = thresh_q;
    low_conf_d  = low_conf_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          for (int i = 0; i < N_CLASS; i++) begin
            bank_d[i] = percent[i*DW +: DW];
          end
          // Element 0 seeds the running best, so the scan starts at 1.
          best_d     = percent[DW-1:0];
          best_idx_d = '0;
          cnt_d      = IW'(1);
          state_d    = SCAN;
`ifdef CONF_THRESH_EN
          thresh_d   = thresh;
`endif
        end
      end
      SCAN: begin
        if (valid_in) begin
          overrun_d = 1'b1;
        end
        best_d     = best_nxt;
        best_idx_d = idx_nxt;
        cnt_d      = cnt_q + IW'(1);
        if (cnt_q == IW'(N_CLASS - 1)) begin
          valid_out_d = 1'b1;
          class_idx_d = idx_nxt;
          max_prob_d  = best_nxt;
          cnt_d       = '0;
          state_d     = IDLE;
`ifdef CONF_THRESH_EN
          low_conf_d  = f_gt(thresh_q, best_nxt);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready tracks the state being entered.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      for (int i = 0; i < N_CLASS; i++) begin
        bank_q[i] <= '0;
      end
      best_q      <= '0;
      best_idx_q  <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      valid_out_q <= 1'b0;
      class_idx_q <= '0;
      max_prob_q  <= '0;
      overrun_q   <= 1'b0;
`ifdef CONF_THRESH_EN
      thresh_q    <= '0;
      low_conf_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      valid_out_q <= valid_out_d;
      class_idx_q <= class_idx_d;
      max_prob_q  <= max_prob_d;
      overrun_q   <= overrun_d;
`ifdef CONF_THRESH_EN
      thresh_q    <= thresh_d;
      low_conf_q  <= low_conf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign valid_out = valid_out_q;
  assign class_idx = class_idx_q;
  assign max_prob  = max_prob_q;
  assign overrun   = overrun_q;
`ifdef CONF_THRESH_EN
  assign low_conf  = low_conf_q;
`endif

endmodule
